// File: rtl/data_mem_arbiter.sv
// Round-robin share of one single-port data RAM among CORES cores; combinational grant, read data one cycle after grant.
// No backpressure: a core holds its request until granted, and every read grant yields exactly one rvalid pulse.
module data_mem_arbiter #(
    parameter int CORES      = 4,
    parameter int WIDTH      = 12,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [CORES-1:0]            req,
    input  logic [CORES-1:0]            we,
    input  logic [CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [CORES*WIDTH-1:0]      core_wdata,
    input  logic [CORES-1:0]            core_done,
    output logic [CORES-1:0]            gnt,
    output logic [CORES-1:0]            rvalid,
    output logic [WIDTH-1:0]            rdata,
    output logic                        mem_wrEn,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]            mem_dataIn,
    input  logic [WIDTH-1:0]            mem_dataOut,
    output logic                        processDone
);

    localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         winner;
    logic                  found;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;

    // Rotating priority search starting at rr_ptr; reset forces no winner.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= CORES) begin
                idx = idx - CORES;
            end
            if (rstN && !found && req[PW'(idx)]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (found) begin
            gnt[winner] = 1'b1;
        end
    end

    assign sel_addr  = core_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = core_wdata[int'(winner)*WIDTH +: WIDTH];

    // Idle cycles re-present the previous address so the RAM output stays stable.
    assign mem_addr   = found ? sel_addr : last_addr;
    assign mem_dataIn = found ? sel_wdata : '0;
    assign mem_wrEn   = found & we[winner];
    assign rdata      = mem_dataOut;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rr_ptr      <= '0;
            rvalid      <= '0;
            last_addr   <= '0;
            processDone <= 1'b0;
        end else begin
            if (found) begin
                rr_ptr <= (int'(winner) == CORES - 1) ? '0 : winner + 1'b1;
            end
            rvalid      <= (found && !we[winner]) ? gnt : '0;
            last_addr   <= mem_addr;
            processDone <= &core_done;
        end
    end

    gnt_onehot: assert property (@(posedge clk) disable iff (!rstN) $onehot0(gnt));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural RAM; rvalid/rdata checked by a scoreboard monitor.
module tb_data_mem_arbiter;

    localparam int CORES = 4;
    localparam int W     = 12;
    localparam int AW    = 12;

    typedef struct {
        int          core;
        logic [W-1:0] data;
        int          cyc;
    } exp_t;

    logic                   clk;
    logic                   rstN;
    logic [CORES-1:0]       req;
    logic [CORES-1:0]       we;
    logic [AW-1:0]          a [CORES];
    logic [W-1:0]           d [CORES];
    logic [CORES*AW-1:0]    core_addr;
    logic [CORES*W-1:0]     core_wdata;
    logic [CORES-1:0]       core_done;
    logic [CORES-1:0]       gnt;
    logic [CORES-1:0]       rvalid;
    logic [W-1:0]           rdata;
    logic                   mem_wrEn;
    logic [AW-1:0]          mem_addr;
    logic [W-1:0]           mem_dataIn;
    logic [W-1:0]           mem_dataOut;
    logic                   processDone;

    int checks;
    int errors;
    int cyc;
    exp_t sb[$];
    exp_t mon_e;

    logic [W-1:0]  ram [4096];
    logic [AW-1:0] ram_addr_q;
    logic          loaded;

    logic [W-1:0] rd_tbl [CORES];

    assign core_addr  = {a[3], a[2], a[1], a[0]};
    assign core_wdata = {d[3], d[2], d[1], d[0]};

    data_mem_arbiter #(.CORES(CORES), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstN(rstN), .req(req), .we(we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_done(core_done),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_wrEn(mem_wrEn), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn),
        .mem_dataOut(mem_dataOut), .processDone(processDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered address, write at the clock edge, data out from the registered address.
    always @(posedge clk) begin
        if (!loaded) begin
            ram[12'h005] <= 12'h055;
            ram[12'h020] <= 12'h111;
            ram[12'h021] <= 12'h222;
            ram[12'h022] <= 12'h333;
            ram[12'h023] <= 12'h444;
            loaded       <= 1'b1;
        end else if (mem_wrEn) begin
            ram[mem_addr] <= mem_dataIn;
        end
        ram_addr_q <= mem_addr;
    end
    assign mem_dataOut = ram[ram_addr_q];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int core, input logic [W-1:0] data);
        sb.push_back('{core, data, cyc + 1});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstN) begin
            if (rvalid != '0) begin
                if (sb.size() == 0) begin
                    chk("rv_unexpected", 32'(rvalid), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rv_onehot", 32'(rvalid), 32'(1) << mon_e.core);
                    chk("rv_rdata", 32'(rdata), 32'(mon_e.data));
                    chk("rv_cycle", cyc, mon_e.cyc);
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                chk("rv_missing", 32'(rvalid), 32'(1) << mon_e.core);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        loaded = 1'b0;
        rd_tbl[0] = 12'h111;
        rd_tbl[1] = 12'h222;
        rd_tbl[2] = 12'h333;
        rd_tbl[3] = 12'h444;
        rstN = 1'b1;
        req = '0;
        we = '0;
        core_done = '0;
        for (int i = 0; i < CORES; i++) begin
            a[i] = 12'h020 + AW'(i);
            d[i] = 12'hF00 + W'(i);
        end

        // Reset with all cores requesting writes
        #2;
        rstN = 1'b0;
        req  = 4'hF;
        we   = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_wren", 32'(mem_wrEn), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_pdone", 32'(processDone), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);

        // Release and rotate continuous reads: 0,1,2,3 then 0..3 twice more
        next_cycle();
        rstN = 1'b1;
        we   = 4'h0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            chk("rot_gnt", 32'(gnt), 32'(1) << (k % 4));
            chk("rot_addr", 32'(mem_addr), 32'h020 + (k % 4));
            push(k % 4, rd_tbl[k % 4]);
        end

        next_cycle();
        req = 4'h0;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt), 32'h0);
        chk("idle_addr_hold", 32'(mem_addr), 32'h023);
        chk("idle_wren", 32'(mem_wrEn), 32'h0);

        // Core 2 writes ABC to 0x010 then reads it back
        next_cycle();
        req = 4'b0100; we = 4'b0100; a[2] = 12'h010; d[2] = 12'hABC;
        @(negedge clk);
        chk("wr_gnt", 32'(gnt), 32'h4);
        chk("wr_wren", 32'(mem_wrEn), 32'h1);
        chk("wr_addr", 32'(mem_addr), 32'h010);
        chk("wr_data", 32'(mem_dataIn), 32'hABC);

        next_cycle();
        we = 4'b0000;
        @(negedge clk);
        chk("rd2_gnt", 32'(gnt), 32'h4);
        chk("rd2_wren", 32'(mem_wrEn), 32'h0);
        push(2, 12'hABC);

        next_cycle();
        req = 4'h0;
        @(negedge clk);
        chk("idle2_addr", 32'(mem_addr), 32'h010);
        chk("idle2_din", 32'(mem_dataIn), 32'h0);

        // Core 1 reads addr 5, core 3 overwrites it next cycle, core 1 re-reads
        next_cycle();
        req = 4'b0010; we = 4'b0000; a[1] = 12'h005;
        @(negedge clk);
        chk("raw_rd_gnt", 32'(gnt), 32'h2);
        push(1, 12'h055);

        next_cycle();
        req = 4'b1000; we = 4'b1000; a[3] = 12'h005; d[3] = 12'h7E7;
        @(negedge clk);
        chk("raw_wr_gnt", 32'(gnt), 32'h8);
        chk("raw_wr_wren", 32'(mem_wrEn), 32'h1);

        next_cycle();
        req = 4'b0010; we = 4'b0000;
        @(negedge clk);
        chk("raw_rd2_gnt", 32'(gnt), 32'h2);
        push(1, 12'h7E7);

        next_cycle();
        req = 4'h0;

        // Read grant to core 0, then reset in the following cycle
        next_cycle();
        req = 4'b0001; a[0] = 12'h020;
        @(negedge clk);
        chk("pre_rst_gnt", 32'(gnt), 32'h1);

        next_cycle();
        rstN = 1'b0;
        req  = 4'hF;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);

        next_cycle();
        rstN = 1'b1;
        req  = 4'h0;
        @(negedge clk);
        chk("post_rst_rvalid", 32'(rvalid), 32'h0);

        next_cycle();
        req = 4'hF;
        @(negedge clk);
        chk("post_rst_ptr", 32'(gnt), 32'h1);
        push(0, 12'h111);

        next_cycle();
        req = 4'h0;

        // processDone aggregation
        next_cycle();
        core_done = 4'b0001;
        next_cycle();
        core_done = 4'b0011;
        next_cycle();
        core_done = 4'b0111;
        next_cycle();
        core_done = 4'b1111;
        @(negedge clk);
        chk("pdone_T", 32'(processDone), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("pdone_T1", 32'(processDone), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("pdone_T2", 32'(processDone), 32'h1);
        next_cycle();
        core_done = 4'b1110;
        @(negedge clk);
        chk("pdone_T3", 32'(processDone), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("pdone_T4", 32'(processDone), 32'h0);

        repeat (3) next_cycle();
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
